// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32 execute-stage helpers: datapath width,
// shift-operation encodings and the iterative shifter state enum.
package riscv_pkg;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = $clog2(XLEN);

    localparam logic [1:0] SH_SLL = 2'b00;
    localparam logic [1:0] SH_SRL = 2'b01;
    localparam logic [1:0] SH_SRA = 2'b10;
    localparam logic [1:0] SH_RSV = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_step.sv
// One-position shift of the working value; the reserved op passes the value
// through untouched so a stray step can never corrupt it.
module shift_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] w,
    input  logic [1:0]      op,
    output logic [XLEN-1:0] shifted
);
    import riscv_pkg::*;

    always_comb begin
        shifted = w;
        case (op)
            SH_SLL:  shifted = {w[XLEN-2:0], 1'b0};
            SH_SRL:  shifted = {1'b0, w[XLEN-1:1]};
            // The sign bit is kept and copied downwards.
            SH_SRA:  shifted = {w[XLEN-1], w[XLEN-1:1]};
            default: shifted = w;
        endcase
    end

endmodule

// File: rtl/seq_shift_unit.sv
// Iterative SLL/SRL/SRA unit: one bit position per clock, handshaked with
// start/busy/done; result is registered on the edge that enters DONE.
module seq_shift_unit #(
    parameter int XLEN    = riscv_pkg::XLEN,
    parameter int SHAMT_W = riscv_pkg::SHAMT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [XLEN-1:0]    operand,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [XLEN-1:0]    result
);
    import riscv_pkg::*;

    state_t               state;
    state_t               nextState;
    logic [XLEN-1:0]      workReg;
    logic [XLEN-1:0]      stepOut;
    logic [SHAMT_W-1:0]   count;
    logic [1:0]           opReg;
    logic                 skipShift;
    logic                 lastStep;

    shift_step #(.XLEN(XLEN)) stepUnit (
        .w       (workReg),
        .op      (opReg),
        .shifted (stepOut)
    );

    assign skipShift = (shamt == '0) || (op == SH_RSV);
    assign lastStep  = (count == SHAMT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // DONE accepts a new start just like IDLE, giving back-to-back issue.
    always_comb begin
        nextState = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    nextState = skipShift ? DONE : SHIFT;
                end else begin
                    nextState = IDLE;
                end
            end
            SHIFT:   nextState = lastStep ? DONE : SHIFT;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SHIFT);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            workReg <= '0;
            count   <= '0;
            opReg   <= SH_SLL;
            result  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        workReg <= operand;
                        count   <= shamt;
                        opReg   <= op;
                        if (skipShift) begin
                            result <= operand;
                        end
                    end
                end
                SHIFT: begin
                    workReg <= stepOut;
                    count   <= count - SHAMT_W'(1);
                    if (lastStep) begin
                        result <= stepOut;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed bench for seq_shift_unit: hand-computed results, latency and busy
// counts, back-to-back issue, ignored mid-shift starts and mid-shift reset.
module tb_seq_shift_unit;
    import riscv_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checkCount = 0;
    int errorCount = 0;
    int latency    = 0;
    int busyCount  = 0;
    int doneSeen   = 0;

    seq_shift_unit dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .operand (operand),
        .shamt   (shamt),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Advance one clock; outputs are then sampled 1ns after the edge.
    task automatic stepCycle();
        if (busy) busyCount++;
        if (done) doneSeen++;
        @(posedge clk);
        #1;
        latency++;
    endtask

    // Present a request for one edge; afterwards we are in cycle k+1.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a,
                                 input logic [4:0] n);
        start   = 1'b1;
        op      = o;
        operand = a;
        shamt   = n;
        @(posedge clk);
        #1;
        start     = 1'b0;
        latency   = 1;
        busyCount = 0;
        doneSeen  = 0;
    endtask

    task automatic waitDone(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (done) return;
            stepCycle();
        end
        checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Full operation: result, latency, busy cycles, one-cycle done, held result.
    task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [4:0] n, input logic [31:0] expected);
        applyStimulus(o, a, n);
        waitDone(tag);
        checkOutput({tag, "_result"}, result, expected);
        checkOutput({tag, "_latency"}, latency,
                    (n == 0 || o == SH_RSV) ? 32'd1 : 32'(n) + 32'd1);
        checkOutput({tag, "_busy"}, busyCount,
                    (n == 0 || o == SH_RSV) ? 32'd0 : 32'(n));
        stepCycle();
        checkOutput({tag, "_donePulse"}, {31'd0, done}, 32'd0);
        checkOutput({tag, "_hold"}, result, expected);
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        op      = SH_SLL;
        operand = '0;
        shamt   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_result", result, 32'd0);

        runOp("sll31", SH_SLL, 32'h0000_0001, 5'd31, 32'h8000_0000);
        runOp("sra4", SH_SRA, 32'hF000_0000, 5'd4, 32'hFF00_0000);
        runOp("srl4", SH_SRL, 32'hF000_0000, 5'd4, 32'h0F00_0000);
        runOp("sra0", SH_SRA, 32'h8765_4321, 5'd0, 32'h8765_4321);
        runOp("rsv7", SH_RSV, 32'h8765_4321, 5'd7, 32'h8765_4321);
        runOp("sra31", SH_SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);

        // Back-to-back: second start issued during the first DONE cycle.
        applyStimulus(SH_SLL, 32'h0000_0001, 5'd2);
        waitDone("b2b1");
        checkOutput("b2b1_result", result, 32'h0000_0004);
        checkOutput("b2b1_latency", latency, 32'd3);
        applyStimulus(SH_SRL, 32'h0000_0008, 5'd3);
        checkOutput("b2b2_noGap", {31'd0, busy}, 32'd1);
        checkOutput("b2b2_doneLow", {31'd0, done}, 32'd0);
        waitDone("b2b2");
        checkOutput("b2b2_result", result, 32'h0000_0001);
        checkOutput("b2b2_latency", latency, 32'd4);
        stepCycle();

        // A start pulsed mid-shift must not disturb the operation in flight.
        applyStimulus(SH_SLL, 32'h0000_0003, 5'd5);
        stepCycle();
        stepCycle();
        start   = 1'b1;
        op      = SH_SRA;
        operand = 32'hF000_0000;
        shamt   = 5'd1;
        stepCycle();
        start = 1'b0;
        waitDone("ignore");
        checkOutput("ignore_result", result, 32'h0000_0060);
        checkOutput("ignore_latency", latency, 32'd6);
        checkOutput("ignore_busy", busyCount, 32'd5);
        stepCycle();

        // Reset in cycle 3 of a 10-cycle shift discards the operation.
        applyStimulus(SH_SRL, 32'hFFFF_FFFF, 5'd10);
        stepCycle();
        stepCycle();
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        checkOutput("midRst_busy", {31'd0, busy}, 32'd0);
        checkOutput("midRst_done", {31'd0, done}, 32'd0);
        checkOutput("midRst_result", result, 32'd0);
        doneSeen = 0;
        repeat (15) stepCycle();
        checkOutput("midRst_noDone", doneSeen, 32'd0);
        runOp("postRst", SH_SRL, 32'hFFFF_FFFF, 5'd10, 32'h003F_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
